countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 233 +++++++++++++++++++++++
 tb/tb_countdown_timer.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// -----------------------------------------------------------------------------
// countdown_timer
//   Tenths-of-a-second countdown timer, 00.0 .. 99.9, held as three BCD digits.
//   The user sets the start value digit by digit in SET, then runs, pauses,
//   stops and restarts it. A prescaler divides i_Clk down to the 0.1 s tick.
//
// Parameters
//   LST_CLK   terminal count of the tick prescaler (100 MHz -> 10 Hz default)
//
// Ports
//   i_Clk     system clock, rising edge
//   i_Rst     asynchronous reset, active-low
//   i_fStart  start/pause button, active-low
//   i_fStop   stop/clear button, active-low
//   i_fSel    select-digit button, active-low
//   i_fUp     increment-digit button, active-low
//   o_Dig0    7-segment pattern (gfedcba, active-high) for tenths
//   o_Dig1    7-segment pattern for seconds-ones
//   o_Dig2    7-segment pattern for seconds-tens
//   o_Value   current BCD value {D2,D1,D0}
//   o_State   SET=00, RUN=01, PAUSE=10, DONE=11
//   o_fDone   expiry indication
//
// Build option
//   COUNTDOWN_AUTO_RELOAD_EN  when defined, expiry reloads the preset, stays in
//                             RUN and pulses o_fDone for one cycle; DONE is
//                             never entered.
// -----------------------------------------------------------------------------

module fnd_decoder (
    input  logic [3:0] bcd_i,
    output logic [6:0] seg_o
);
    always_comb begin
        seg_o = 7'h00;
        case (bcd_i)
            4'd0:    seg_o = 7'h3F;
            4'd1:    seg_o = 7'h06;
            4'd2:    seg_o = 7'h5B;
            4'd3:    seg_o = 7'h4F;
            4'd4:    seg_o = 7'h66;
            4'd5:    seg_o = 7'h6D;
            4'd6:    seg_o = 7'h7D;
            4'd7:    seg_o = 7'h07;
            4'd8:    seg_o = 7'h7F;
            4'd9:    seg_o = 7'h6F;
            default: seg_o = 7'h00;
        endcase
    end
endmodule

module countdown_timer #(
    parameter int LST_CLK = 9_999_999
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_fStart,
    input  logic        i_fStop,
    input  logic        i_fSel,
    input  logic        i_fUp,
    output logic [6:0]  o_Dig0,
    output logic [6:0]  o_Dig1,
    output logic [6:0]  o_Dig2,
    output logic [11:0] o_Value,
    output logic [1:0]  o_State,
    output logic        o_fDone
);
    localparam int PW = (LST_CLK < 1) ? 1 : $clog2(LST_CLK + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(LST_CLK);

    typedef enum logic [1:0] {
        ST_SET   = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_DONE  = 2'b11
    } state_t;

    state_t        state_q;
    logic [11:0]   val_q;
    logic [11:0]   preset_q;
    logic [1:0]    ptr_q;
    logic [PW-1:0] presc_q;
    logic [3:0]    btn_prev_q;   // {up, sel, stop, start}
    logic          armed_q;
    logic          done_q;

    logic [3:0]  btn_now;
    logic [3:0]  btn_ev;
    logic        start_ev, stop_ev, sel_ev, up_ev;
    logic        tick;
    logic [11:0] set_val_d;
    logic [11:0] dec_val_d;
    logic [1:0]  ptr_d;

    // Increment one BCD digit, wrapping 9 -> 0 without carry.
    function automatic logic [3:0] inc10(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    // Subtract 0.1 from a three-digit BCD value with borrow.
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] d0, d1, d2;
        d0 = v[3:0];
        d1 = v[7:4];
        d2 = v[11:8];
        if (d0 != 4'd0) begin
            d0 = d0 - 4'd1;
        end else begin
            d0 = 4'd9;
            if (d1 != 4'd0) begin
                d1 = d1 - 4'd1;
            end else begin
                d1 = 4'd9;
                d2 = d2 - 4'd1;
            end
        end
        return {d2, d1, d0};
    endfunction

    // armed_q suppresses the first sample after reset so a button held low
    // through reset is taken as the starting level, not as a press.
    assign btn_now  = {i_fUp, i_fSel, i_fStop, i_fStart};
    assign btn_ev   = armed_q ? (btn_prev_q & ~btn_now) : 4'b0000;
    assign start_ev = btn_ev[0];
    assign stop_ev  = btn_ev[1];
    assign sel_ev   = btn_ev[2];
    assign up_ev    = btn_ev[3];

    assign tick      = (presc_q == PRESC_LAST);
    assign dec_val_d = bcd_dec(val_q);
    assign ptr_d     = (ptr_q == 2'd2) ? 2'd0 : ptr_q + 2'd1;

    // The increment uses the pointer before any same-cycle Sel moves it.
    always_comb begin
        set_val_d = val_q;
        if (up_ev) begin
            case (ptr_q)
                2'd0:    set_val_d[3:0]  = inc10(val_q[3:0]);
                2'd1:    set_val_d[7:4]  = inc10(val_q[7:4]);
                default: set_val_d[11:8] = inc10(val_q[11:8]);
            endcase
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q    <= ST_SET;
            val_q      <= '0;
            preset_q   <= '0;
            ptr_q      <= '0;
            presc_q    <= '0;
            btn_prev_q <= '1;
            armed_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            btn_prev_q <= btn_now;
            armed_q    <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            done_q     <= 1'b0;
`endif
            case (state_q)
                ST_SET: begin
                    if (stop_ev) begin
                        val_q <= '0;
                        ptr_q <= '0;
                    end else if (start_ev && (val_q != 12'h000)) begin
                        preset_q <= val_q;
                        presc_q  <= '0;
                        state_q  <= ST_RUN;
                    end else begin
                        val_q <= set_val_d;
                        if (sel_ev) ptr_q <= ptr_d;
                    end
                end
                ST_RUN: begin
                    // Buttons win over a coincident tick.
                    if (stop_ev) begin
                        val_q   <= preset_q;
                        ptr_q   <= '0;
                        presc_q <= '0;
                        state_q <= ST_SET;
                    end else if (start_ev) begin
                        state_q <= ST_PAUSE;
                    end else if (tick) begin
                        presc_q <= '0;
                        if (val_q == 12'h001) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            val_q   <= preset_q;
                            done_q  <= 1'b1;
`else
                            val_q   <= 12'h000;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
`endif
                        end else begin
                            val_q <= dec_val_d;
                        end
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                end
                ST_PAUSE: begin
                    if (stop_ev) begin
                        val_q   <= preset_q;
                        ptr_q   <= '0;
                        presc_q <= '0;
                        state_q <= ST_SET;
                    end else if (start_ev) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    if (stop_ev || start_ev) begin
                        val_q   <= preset_q;
                        ptr_q   <= '0;
                        presc_q <= '0;
                        done_q  <= 1'b0;
                        state_q <= ST_SET;
                    end
                end
            endcase
        end
    end

    assign o_Value = val_q;
    assign o_State = state_q;
    assign o_fDone = done_q;

    fnd_decoder u_fnd0 (.bcd_i(val_q[3:0]),  .seg_o(o_Dig0));
    fnd_decoder u_fnd1 (.bcd_i(val_q[7:4]),  .seg_o(o_Dig1));
    fnd_decoder u_fnd2 (.bcd_i(val_q[11:8]), .seg_o(o_Dig2));

endmodule

// File: tb/tb_countdown_timer.sv
// -----------------------------------------------------------------------------
// tb_countdown_timer
//   Directed test of countdown_timer with LST_CLK=3 (one tick every 4 clocks).
//   The driver pushes hand-computed expectations, each tagged with the clock
//   cycle after which it must hold; a monitor pops and compares them on the
//   falling edge. Honours COUNTDOWN_AUTO_RELOAD_EN for the expiry scenarios.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_countdown_timer;
    localparam int LST = 3;
    localparam logic [1:0] S_SET = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_DONE = 2'b11;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_n = 1'b1, stop_n = 1'b1, sel_n = 1'b1, up_n = 1'b1;
    logic [6:0]  dig0, dig1, dig2;
    logic [11:0] value;
    logic [1:0]  state;
    logic        fdone;

    always #5 clk = ~clk;

    countdown_timer #(.LST_CLK(LST)) dut (
        .i_Clk   (clk),
        .i_Rst   (rst_n),
        .i_fStart(start_n),
        .i_fStop (stop_n),
        .i_fSel  (sel_n),
        .i_fUp   (up_n),
        .o_Dig0  (dig0),
        .o_Dig1  (dig1),
        .o_Dig2  (dig2),
        .o_Value (value),
        .o_State (state),
        .o_fDone (fdone)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [11:0] val;
        logic [1:0]  st;
        logic        dn;
        string       nm;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int total = 0;
    int bad = 0;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h00;
        endcase
    endfunction

    // Monitor: compare every expectation whose cycle has been reached.
    initial begin
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                cur = sb.pop_front();
                total++;
                if (value !== cur.val || state !== cur.st || fdone !== cur.dn ||
                    dig0 !== seg_of(cur.val[3:0]) || dig1 !== seg_of(cur.val[7:4]) ||
                    dig2 !== seg_of(cur.val[11:8])) begin
                    bad++;
                    $display("FAIL %s: got val=%h st=%b done=%b seg=%h/%h/%h, want val=%h st=%b done=%b seg=%h/%h/%h",
                             cur.nm, value, state, fdone, dig2, dig1, dig0,
                             cur.val, cur.st, cur.dn, seg_of(cur.val[11:8]),
                             seg_of(cur.val[7:4]), seg_of(cur.val[3:0]));
                end
            end
        end
    end

    // All driver activity happens 2 ns after a rising edge.
    task automatic clk_wait(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Press a button set for one clock; the event edge is the second posedge
    // and on return cyc equals that edge.
    task automatic press(input logic s, input logic p, input logic l, input logic u);
        @(posedge clk); #2;
        start_n = ~s; stop_n = ~p; sel_n = ~l; up_n = ~u;
        @(posedge clk); #2;
        start_n = 1'b1; stop_n = 1'b1; sel_n = 1'b1; up_n = 1'b1;
    endtask

    task automatic expect_at(input int d, input logic [11:0] v, input logic [1:0] s,
                             input logic dn, input string nm);
        exp_t e;
        e.due = cyc + d;
        e.val = v;
        e.st  = s;
        e.dn  = dn;
        e.nm  = nm;
        sb.push_back(e);
    endtask

    initial begin
        int guard;
        // Reset with Up held low throughout.
        rst_n = 1'b0;
        up_n  = 1'b0;
        clk_wait(2);
        expect_at(0, 12'h000, S_SET, 1'b0, "reset_state");
        clk_wait(1);
        rst_n = 1'b1;
        clk_wait(3);
        expect_at(0, 12'h000, S_SET, 1'b0, "held_through_reset");
        clk_wait(1);
        up_n = 1'b1;
        clk_wait(2);
        expect_at(0, 12'h000, S_SET, 1'b0, "release_no_event");

        // Digit entry
        press(0, 0, 1, 0);
        press(0, 0, 0, 1);
        press(0, 0, 0, 1);
        expect_at(0, 12'h020, S_SET, 1'b0, "sel_up2");
        press(0, 0, 1, 0);
        repeat (3) press(0, 0, 0, 1);
        expect_at(0, 12'h320, S_SET, 1'b0, "entry_320");
        press(0, 1, 0, 0);
        expect_at(0, 12'h000, S_SET, 1'b0, "set_stop_clear");
        repeat (9) press(0, 0, 0, 1);
        expect_at(0, 12'h009, S_SET, 1'b0, "up_to_9");
        press(0, 0, 0, 1);
        expect_at(0, 12'h000, S_SET, 1'b0, "up_wrap_nocarry");
        press(1, 0, 0, 0);
        expect_at(0, 12'h000, S_SET, 1'b0, "start_zero_ignored");

        // Preset 00.2 and run to expiry
        press(0, 0, 0, 1);
        press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        expect_at(0, 12'h002, S_RUN, 1'b0, "start_run");
`ifndef COUNTDOWN_AUTO_RELOAD_EN
        expect_at(3, 12'h002, S_RUN, 1'b0, "pre_tick1");
        expect_at(4, 12'h001, S_RUN, 1'b0, "tick1");
        expect_at(7, 12'h001, S_RUN, 1'b0, "pre_tick2");
        expect_at(8, 12'h000, S_DONE, 1'b1, "expire_done");
        clk_wait(8);
        clk_wait(3);
        expect_at(0, 12'h000, S_DONE, 1'b1, "done_hold");
        press(1, 0, 0, 0);
        expect_at(0, 12'h002, S_SET, 1'b0, "done_start_restore");
`else
        expect_at(3, 12'h002, S_RUN, 1'b0, "ar_pre_tick1");
        expect_at(4, 12'h001, S_RUN, 1'b0, "ar_tick1");
        expect_at(7, 12'h001, S_RUN, 1'b0, "ar_pre_tick2");
        expect_at(8, 12'h002, S_RUN, 1'b1, "ar_reload");
        expect_at(9, 12'h002, S_RUN, 1'b0, "ar_pulse_end");
        clk_wait(9);
        press(0, 1, 0, 0);
        expect_at(0, 12'h002, S_SET, 1'b0, "ar_stop_restore");
        press(0, 1, 0, 0);
        press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        expect_at(0, 12'h001, S_RUN, 1'b0, "ar_run_001");
        expect_at(3, 12'h001, S_RUN, 1'b0, "ar_a3");
        expect_at(4, 12'h001, S_RUN, 1'b1, "ar_a4_pulse");
        expect_at(5, 12'h001, S_RUN, 1'b0, "ar_a5");
        expect_at(7, 12'h001, S_RUN, 1'b0, "ar_a7");
        expect_at(8, 12'h001, S_RUN, 1'b1, "ar_a8_pulse");
        expect_at(9, 12'h001, S_RUN, 1'b0, "ar_a9");
        clk_wait(9);
        press(0, 1, 0, 0);
        expect_at(0, 12'h001, S_SET, 1'b0, "ar_stop_001");
`endif

        // Borrow, pause, resume from held prescaler count
        press(0, 1, 0, 0);
        expect_at(0, 12'h000, S_SET, 1'b0, "clear_again");
        press(0, 0, 1, 0);
        press(0, 0, 0, 1);
        press(1, 0, 0, 0);
        expect_at(0, 12'h010, S_RUN, 1'b0, "run_010");
        expect_at(4, 12'h009, S_RUN, 1'b0, "borrow_009");
        clk_wait(4);
        press(1, 0, 0, 0);
        expect_at(0, 12'h009, S_PAUSE, 1'b0, "pause");
        clk_wait(20);
        expect_at(0, 12'h009, S_PAUSE, 1'b0, "pause_hold20");
        press(1, 0, 0, 0);
        expect_at(0, 12'h009, S_RUN, 1'b0, "resume");
        expect_at(2, 12'h009, S_RUN, 1'b0, "resume_pre_tick");
        expect_at(3, 12'h008, S_RUN, 1'b0, "resume_tick");
        clk_wait(3);

        // Start and Stop together: Stop wins
        press(1, 1, 0, 0);
        expect_at(0, 12'h010, S_SET, 1'b0, "start_stop_same");

        // Stop on a tick edge
        press(1, 0, 0, 0);
        clk_wait(2);
        press(0, 1, 0, 0);
        expect_at(0, 12'h010, S_SET, 1'b0, "stop_on_tick");

        // Start on a tick edge, then Sel/Up ignored in PAUSE
        press(1, 0, 0, 0);
        clk_wait(2);
        press(1, 0, 0, 0);
        expect_at(0, 12'h010, S_PAUSE, 1'b0, "start_on_tick");
        press(0, 0, 1, 1);
        expect_at(0, 12'h010, S_PAUSE, 1'b0, "ignore_sel_up_pause");
        press(0, 1, 0, 0);
        expect_at(0, 12'h010, S_SET, 1'b0, "pause_stop_restore");

        // Sel and Up together: increment uses old pointer
        press(0, 0, 1, 1);
        expect_at(0, 12'h011, S_SET, 1'b0, "sel_up_same");
        press(0, 0, 0, 1);
        expect_at(0, 12'h021, S_SET, 1'b0, "ptr_after_sel");

        // Asynchronous reset mid-RUN at 05.3
        press(0, 1, 0, 0);
        repeat (3) press(0, 0, 0, 1);
        press(0, 0, 1, 0);
        repeat (5) press(0, 0, 0, 1);
        expect_at(0, 12'h053, S_SET, 1'b0, "val_053");
        press(1, 0, 0, 0);
        expect_at(0, 12'h053, S_RUN, 1'b0, "run_053");
        clk_wait(2);
        rst_n = 1'b0;
        #1;
        total++;
        if (value !== 12'h000 || state !== S_SET || fdone !== 1'b0) begin
            bad++;
            $display("FAIL async_reset_immediate: got val=%h st=%b done=%b",
                     value, state, fdone);
        end
        total++;
        if (dig0 !== 7'h3F || dig1 !== 7'h3F || dig2 !== 7'h3F) begin
            bad++;
            $display("FAIL async_reset_segments: got seg=%h/%h/%h", dig2, dig1, dig0);
        end
        expect_at(0, 12'h000, S_SET, 1'b0, "async_reset");
        clk_wait(1);
        rst_n = 1'b1;
        clk_wait(2);
        expect_at(0, 12'h000, S_SET, 1'b0, "after_reset");

        // Drain the scoreboard with a bounded wait
        guard = 0;
        while (sb.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: never checked, want val=%h st=%b done=%b",
                     cur.nm, cur.val, cur.st, cur.dn);
        end
        if (total < 12) begin
            bad++;
            $display("FAIL too few checks executed: total=%0d", total);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
